// File: rtl/trace_recorder.sv
// Commit-trace recorder: packs each cycle's register/memory events into one timestamped entry and queues it.
// Entry visible the cycle after capture; a full FIFO drops new entries unless a pop frees a slot that same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; consumers only look at it while level is non-zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

  assign popData = mem[rdPtr];
endmodule

module trace_recorder #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic                   clear,
  input  logic                   RegWriteSignal,
  input  logic [4:0]             RegNum,
  input  logic [31:0]            RegData,
  input  logic                   WriteEnable,
  input  logic                   ReadEnable,
  input  logic [8:0]             Address,
  input  logic [31:0]            WRData,
  input  logic [31:0]            RDData,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [CYCLE_W-1:0]     trace_cycle,
  output logic                   trace_reg_v,
  output logic [4:0]             trace_reg_num,
  output logic [31:0]            trace_reg_data,
  output logic [1:0]             trace_mem_kind,
  output logic [8:0]             trace_mem_addr,
  output logic [31:0]            trace_mem_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count,
  output logic                   overflow,
  output logic                   conflict
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic               regV;
    logic [4:0]         regNum;
    logic [31:0]        regData;
    logic [1:0]         memKind;
    logic [8:0]         memAddr;
    logic [31:0]        memData;
  } entry_t;

  logic [CYCLE_W-1:0] cyc;
  entry_t             newEntry;
  entry_t             headEntry;
  entry_t             headShown;
  logic               evt;
  logic               pushReq;
  logic               push;
  logic               pop;
  logic               full;
  logic               drop;

  assign evt     = trace_en & (RegWriteSignal | WriteEnable | ReadEnable);
  assign pushReq = evt & ~clear;
  assign pop     = trace_valid & trace_ready & ~clear;
  assign full    = (level == LW'(DEPTH));
  assign push    = pushReq & (~full | pop);
  assign drop    = pushReq & full & ~pop;

  always_comb begin
    newEntry         = '0;
    newEntry.cycle   = cyc;
    newEntry.regV    = RegWriteSignal;
    newEntry.memKind = {WriteEnable, ReadEnable};
    if (RegWriteSignal) begin
      newEntry.regNum  = RegNum;
      newEntry.regData = RegData;
    end
    if (WriteEnable | ReadEnable) begin
      newEntry.memAddr = Address;
      newEntry.memData = WriteEnable ? WRData : RDData;
    end
  end

  trace_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .pushData (newEntry),
    .pop      (pop),
    .popData  (headEntry),
    .level    (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc        <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      cyc <= cyc + CYCLE_W'(1);
      if (clear) begin
        drop_count <= '0;
        overflow   <= 1'b0;
        conflict   <= 1'b0;
      end else begin
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        if (trace_en & WriteEnable & ReadEnable) conflict <= 1'b1;
      end
    end
  end

  // Head fields read as zero while empty so reset leaves every output at 0.
  assign trace_valid    = (level != '0);
  assign headShown      = trace_valid ? headEntry : '0;
  assign trace_cycle    = headShown.cycle;
  assign trace_reg_v    = headShown.regV;
  assign trace_reg_num  = headShown.regNum;
  assign trace_reg_data = headShown.regData;
  assign trace_mem_kind = headShown.memKind;
  assign trace_mem_addr = headShown.memAddr;
  assign trace_mem_data = headShown.memData;
endmodule

// File: tb/tb_trace_recorder.sv
// Scoreboard bench for trace_recorder: a reference model queues expected entries and counters each edge.
module tb_trace_recorder;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  typedef struct packed {
    logic [CW-1:0] cycle;
    logic          regV;
    logic [4:0]    regNum;
    logic [31:0]   regData;
    logic [1:0]    memKind;
    logic [8:0]    memAddr;
    logic [31:0]   memData;
  } entry_t;

  logic clk = 0, rst = 1, trace_en = 0, clear = 0;
  logic RegWriteSignal = 0, WriteEnable = 0, ReadEnable = 0, trace_ready = 0;
  logic [4:0] RegNum = 0;
  logic [31:0] RegData = 0, WRData = 0, RDData = 0;
  logic [8:0] Address = 0;
  logic trace_valid, trace_reg_v, overflow, conflict;
  logic [CW-1:0] trace_cycle;
  logic [4:0] trace_reg_num;
  logic [31:0] trace_reg_data, trace_mem_data;
  logic [1:0] trace_mem_kind;
  logic [8:0] trace_mem_addr;
  logic [4:0] level;
  logic [15:0] drop_count;

  trace_recorder #(.DEPTH(DEPTH), .CYCLE_W(CW)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear),
    .RegWriteSignal(RegWriteSignal), .RegNum(RegNum), .RegData(RegData),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .Address(Address),
    .WRData(WRData), .RDData(RDData), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cycle(trace_cycle), .trace_reg_v(trace_reg_v), .trace_reg_num(trace_reg_num),
    .trace_reg_data(trace_reg_data), .trace_mem_kind(trace_mem_kind),
    .trace_mem_addr(trace_mem_addr), .trace_mem_data(trace_mem_data), .level(level),
    .drop_count(drop_count), .overflow(overflow), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  entry_t expQ[$];
  int tbCyc = 0, lastTs = -1;
  logic [15:0] expDrop = 0;
  logic expOvf = 0, expConf = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setEv(input logic rw, input logic [4:0] rn, input logic [31:0] rd,
                       input logic we, input logic re, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] rdd);
    RegWriteSignal = rw; RegNum = rn; RegData = rd;
    WriteEnable = we; ReadEnable = re; Address = a; WRData = wd; RDData = rdd;
  endtask

  task automatic setIdle();
    setEv(0, 5'($urandom), $urandom, 0, 0, 9'($urandom), $urandom, $urandom);
  endtask

  task automatic resetModel();
    expQ.delete(); tbCyc = 0; lastTs = -1; expDrop = 0; expOvf = 0; expConf = 0;
  endtask

  // One clock edge: score the handshake, advance the model, then check registered state.
  task automatic tick();
    logic ev, popM, fullM;
    entry_t e, h;
    ev    = trace_en & (RegWriteSignal | WriteEnable | ReadEnable);
    popM  = (expQ.size() != 0) & trace_ready & ~clear;
    fullM = (expQ.size() == DEPTH);
    if (popM) begin
      h = {trace_cycle, trace_reg_v, trace_reg_num, trace_reg_data,
           trace_mem_kind, trace_mem_addr, trace_mem_data};
      checkVal("head", h, expQ[0]);
      checkVal("ts_order", int'(trace_cycle) > lastTs, 1);
      lastTs = int'(trace_cycle);
    end
    e = '0;
    e.cycle = CW'(tbCyc);
    e.regV = RegWriteSignal;
    e.memKind = {WriteEnable, ReadEnable};
    if (RegWriteSignal) begin e.regNum = RegNum; e.regData = RegData; end
    if (WriteEnable) begin e.memAddr = Address; e.memData = WRData; end
    else if (ReadEnable) begin e.memAddr = Address; e.memData = RDData; end
    if (clear) begin
      expQ.delete(); expDrop = 0; expOvf = 0; expConf = 0;
    end else begin
      if (popM) void'(expQ.pop_front());
      if (ev) begin
        if (!fullM || popM) expQ.push_back(e);
        else begin
          if (expDrop != 16'hFFFF) expDrop++;
          expOvf = 1;
        end
      end
      if (trace_en & WriteEnable & ReadEnable) expConf = 1;
    end
    @(posedge clk);
    tbCyc++;
    #1;
    checkVal("valid", trace_valid, expQ.size() != 0);
    checkVal("level", level, expQ.size());
    checkVal("drop_count", drop_count, expDrop);
    checkVal("overflow", overflow, expOvf);
    checkVal("conflict", conflict, expConf);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal(tag, {trace_valid, trace_cycle, trace_reg_v, trace_reg_num, trace_reg_data,
                   trace_mem_kind, trace_mem_addr, trace_mem_data, level, drop_count,
                   overflow, conflict}, '0);
  endtask

  initial begin
    #2;
    checkAllZero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    resetModel();
    trace_en = 1;

    // Single register write into an empty FIFO.
    setEv(1, 5, 32'h0000_002A, 0, 0, 9'h1FF, 32'h1234_5678, 32'h8765_4321);
    tick();
    checkVal("t1_cycle", trace_cycle, 0);
    checkVal("t1_reg", {trace_reg_v, trace_reg_num, trace_reg_data}, {1'b1, 5'd5, 32'd42});
    checkVal("t1_kind", trace_mem_kind, 2'b00);
    setIdle(); trace_ready = 1; tick();

    // Register write plus memory write in one cycle.
    trace_ready = 0;
    setEv(1, 3, 32'd7, 1, 0, 9'd12, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    tick();
    checkVal("t2_level", level, 1);
    checkVal("t2_mem", {trace_mem_kind, trace_mem_addr, trace_mem_data}, {2'b10, 9'd12, 32'hDEAD_BEEF});
    setIdle(); trace_ready = 1; tick();

    // Memory read, then a read/write conflict.
    trace_ready = 0;
    setEv(0, 9, 32'h5555_5555, 0, 1, 9'd4, 32'hAAAA_AAAA, 32'hFFFF_FFF6);
    tick();
    checkVal("t3_mem", {trace_mem_kind, trace_mem_data, trace_reg_v}, {2'b01, 32'hFFFF_FFF6, 1'b0});
    setIdle(); trace_ready = 1; tick();
    trace_ready = 0;
    setEv(0, 0, 0, 1, 1, 9'd8, 32'hCAFE_0001, 32'h0000_0002);
    tick();
    checkVal("t4_kind", {trace_mem_kind, trace_mem_data, conflict}, {2'b11, 32'hCAFE_0001, 1'b1});
    setIdle(); trace_ready = 1;
    repeat (3) tick();
    checkVal("t4_sticky", conflict, 1);

    // 20 events against a stalled consumer.
    trace_ready = 0;
    for (int i = 0; i < 20; i++) begin
      setEv(1, 5'(i), $urandom, i[0], 0, 9'(i), $urandom, $urandom);
      tick();
    end
    checkVal("ovf_level", level, 16);
    checkVal("ovf_drops", drop_count, 4);
    checkVal("ovf_flag", overflow, 1);
    // Full FIFO: pop and push together must not drop.
    trace_ready = 1;
    setEv(1, 5'd31, 32'h1357_9BDF, 0, 0, 0, 0, 0);
    tick();
    checkVal("full_pp_level", level, 16);
    checkVal("full_pp_drops", drop_count, 4);
    setIdle();
    repeat (DEPTH + 1) tick();

    // Clear together with an event at level 3, drop_count 2.
    clear = 1; tick(); clear = 0;
    trace_ready = 0;
    for (int i = 0; i < 18; i++) begin
      setEv(0, 0, 0, 0, 1, 9'(i + 100), $urandom, $urandom);
      tick();
    end
    setIdle(); trace_ready = 1;
    repeat (13) tick();
    checkVal("pre_clear", {level, drop_count}, {5'd3, 16'd2});
    setEv(1, 1, 32'h1, 0, 0, 0, 0, 0); clear = 1;
    tick();
    clear = 0;
    checkVal("clear_state", {level, drop_count, overflow, trace_valid}, '0);
    trace_ready = 0;
    setEv(1, 2, 32'h2, 0, 0, 0, 0, 0);
    tick();
    checkVal("clear_cyc", trace_cycle, CW'(tbCyc - 1));

    // Reset mid-drain.
    setEv(1, 4, 32'h4, 0, 0, 0, 0, 0);
    repeat (4) tick();
    setIdle(); trace_ready = 1; tick();
    rst = 1;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk);
    #1 rst = 0;
    resetModel();
    setEv(1, 6, 32'h6, 0, 0, 0, 0, 0); trace_ready = 0;
    tick();
    checkVal("post_reset_cyc", trace_cycle, 0);

    // Random traffic with occasional clears and enable gaps.
    for (int i = 0; i < 400; i++) begin
      trace_en    = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 49) == 0);
      trace_ready = ($urandom_range(0, 2) == 0);
      setEv(1'($urandom_range(0, 1)), 5'($urandom), $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 9'($urandom), $urandom, $urandom);
      tick();
    end
    clear = 0; trace_en = 0; trace_ready = 1; setIdle();
    repeat (DEPTH + 1) tick();
    checkVal("final_empty", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
